cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates one shared RAM port between an icache (read-only) and a dcache (read/write).
// Optional macro ARB_FAIR_EN alternates grants when both requestors are pending.
module cache_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_GRANT = 2'd1,
        I_GRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t state_q, state_d;
    logic   ram_err_q, ram_err_d;
    logic   d_req_s, access_s, prefer_i_s;

    assign d_req_s  = dREN | dWEN;
    assign access_s = (ramstate == RAM_ACCESS);
    assign iload    = ramload;
    assign dload    = ramload;
    assign ram_err  = ram_err_q;

`ifdef ARB_FAIR_EN
    logic last_d_q, last_d_d;

    assign prefer_i_s = last_d_q;

    // remember which side completed last so a contended IDLE yields to the other
    always_comb begin
        last_d_d = last_d_q;
        if ((state_q == D_GRANT) && access_s) begin
            last_d_d = 1'b1;
        end else if ((state_q == I_GRANT) && access_s) begin
            last_d_d = 1'b0;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // fairness bit register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign prefer_i_s = 1'b0;
`endif

    // next-state, sticky error and RAM port steering
    always_comb begin
        state_d   = state_q;
        ram_err_d = ram_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = 32'd0;
        ramstore  = 32'd0;
        case (state_q)
            IDLE: begin
                if (d_req_s && !(iREN && prefer_i_s)) begin
                    state_d = D_GRANT;
                end else if (iREN) begin
                    state_d = I_GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            D_GRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~access_s;
                if (ramstate == RAM_ERROR) begin
                    ram_err_d = 1'b1;
                end else begin
                    ram_err_d = ram_err_q;
                end
                // a dropped request abandons the word so the other side is not starved
                if (access_s || !d_req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = D_GRANT;
                end
            end
            I_GRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~access_s;
                if (ramstate == RAM_ERROR) begin
                    ram_err_d = 1'b1;
                end else begin
                    ram_err_d = ram_err_q;
                end
                if (access_s || !iREN) begin
                    state_d = IDLE;
                end else begin
                    state_d = I_GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and sticky error registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_err_q <= ram_err_d;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level ownership model. Honours ARB_FAIR_EN.
module tb_cache_arbiter;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    cache_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache), sticky error, last served side
    int owner;
    bit m_err, m_last_d;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner    <= 0;
            m_err    <= 1'b0;
            m_last_d <= 1'b0;
        end else if (owner == 0) begin
            if ((dREN || dWEN) && !(iREN && FAIR && m_last_d)) owner <= 1;
            else if (iREN) owner <= 2;
        end else begin
            if (ramstate == 2'd3) m_err <= 1'b1;
            if (ramstate == 2'd2) begin
                m_last_d <= (owner == 1);
                owner    <= 0;
            end else if (owner == 1 && !(dREN || dWEN)) owner <= 0;
            else if (owner == 2 && !iREN) owner <= 0;
        end
    end

    task automatic model_expect(output logic [132:0] v);
        logic ewi, ewd, er, ew;
        logic [31:0] ea, es;
        ewi = 1'b1; ewd = 1'b1; er = 1'b0; ew = 1'b0; ea = 32'd0; es = 32'd0;
        if (owner == 1) begin
            ea = daddr; es = dstore; ew = dWEN; er = dREN && !dWEN;
            ewd = (ramstate != 2'd2);
        end else if (owner == 2) begin
            ea = iaddr; er = iREN;
            ewi = (ramstate != 2'd2);
        end
        v = {ewi, ewd, er, ew, m_err, ea, es, ramload, ramload};
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        ramstate = 2'd0; ramload = 32'd0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        #12;
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, ram_err} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=11000", {iwait, dwait, ramREN, ramWEN, ram_err});
        end
        checks++;
        if ({ramaddr, ramstore} !== 64'd0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", {ramaddr, ramstore});
        end
        next_cycle();
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_dcache_read();
        dREN = 1'b1; daddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = 2'd1;
        @(negedge CLK);
        checks++;
        if ({dwait, ramREN} !== 2'b10) begin
            failures++;
            $display("FAIL dread_idle got=%b exp=10", {dwait, ramREN});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({dwait, ramREN, ramWEN, ramaddr} !== {3'b110, 32'h100}) begin
            failures++;
            $display("FAIL dread_grant1 got=%h exp=%h", {dwait, ramREN, ramWEN, ramaddr}, {3'b110, 32'h100});
        end
        next_cycle();
        ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if ({dwait, iwait, dload} !== {2'b01, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL dread_done got=%h exp=%h", {dwait, iwait, dload}, {2'b01, 32'hDEADBEEF});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({dwait, ramREN} !== 2'b10) begin
            failures++;
            $display("FAIL dread_idle_after got=%b exp=10", {dwait, ramREN});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_write_priority();
        iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678; ramstate = 2'd1;
        @(negedge CLK);
        checks++;
        if ({iwait, ramWEN} !== 2'b10) begin
            failures++;
            $display("FAIL prio_idle got=%b exp=10", {iwait, ramWEN});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore} !== {4'b1101, 32'h40, 32'h12345678}) begin
            failures++;
            $display("FAIL prio_dgrant got=%h exp=%h", {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore},
                     {4'b1101, 32'h40, 32'h12345678});
        end
        next_cycle();
        ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait} !== 2'b10) begin
            failures++;
            $display("FAIL prio_done got=%b exp=10", {iwait, dwait});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_drop();
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
        next_cycle();
        dREN = 1'b0;
        @(negedge CLK);
        checks++;
        if ({ramREN, dwait} !== 2'b01) begin
            failures++;
            $display("FAIL drop_strobe got=%b exp=01", {ramREN, dwait});
        end
        next_cycle();
        dREN = 1'b1; ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if ({ramREN, dwait} !== 2'b01) begin
            failures++;
            $display("FAIL drop_idle got=%b exp=01", {ramREN, dwait});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_error();
        iREN = 1'b1; iaddr = 32'h0ABC; ramload = 32'h55AA33CC; ramstate = 2'd0;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            ramstate = 2'd3;
            @(negedge CLK);
            checks++;
            if ({iwait, ramREN, ram_err} !== {2'b11, (k > 0)}) begin
                failures++;
                $display("FAIL err_hold%0d got=%b exp=%b", k, {iwait, ramREN, ram_err}, {2'b11, (k > 0)});
            end
            next_cycle();
        end
        ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if ({iwait, ram_err, iload} !== {2'b01, 32'h55AA33CC}) begin
            failures++;
            $display("FAIL err_done got=%h exp=%h", {iwait, ram_err, iload}, {2'b01, 32'h55AA33CC});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ram_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", ram_err);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        dWEN = 1'b1; daddr = 32'h44; dstore = 32'hCAFE0001; ramstate = 2'd1;
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramWEN !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_grant got=%b exp=1", ramWEN);
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if ({ramWEN, dwait, ram_err} !== 3'b010) begin
            failures++;
            $display("FAIL rstmid_abort got=%b exp=010", {ramWEN, dwait, ram_err});
        end
        next_cycle();
        clear_inputs();
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_fairness();
        byte who[$];
        byte exp_seq [4];
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h10; daddr = 32'h20; ramstate = 2'd2;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (dwait == 1'b0) who.push_back("D");
            if (iwait == 1'b0) who.push_back("I");
            next_cycle();
        end
        for (int k = 0; k < 4; k++) exp_seq[k] = (FAIR && (k % 2 == 1)) ? "I" : "D";
        checks++;
        if (who.size() != 4) begin
            failures++;
            $display("FAIL fair_count got=%0d exp=4", who.size());
        end
        for (int k = 0; k < 4 && k < who.size(); k++) begin
            checks++;
            if (who[k] !== exp_seq[k]) begin
                failures++;
                $display("FAIL fair_seq%0d got=%c exp=%c", k, who[k], exp_seq[k]);
            end
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        logic [132:0] exp_v, got_v;
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = $urandom_range(0, 1);
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            @(negedge CLK);
            model_expect(exp_v);
            got_v = {iwait, dwait, ramREN, ramWEN, ram_err, ramaddr, ramstore, iload, dload};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (bad < 10) $display("FAIL random_c%0d got=%h exp=%h", c, got_v, exp_v);
                bad++;
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_dcache_read();
        test_write_priority();
        test_drop();
        test_error();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
